// File: rtl/space_wire_stat_pkg.sv
// Shared encodings for the SpaceWire statistics access controller:
// command codes, controller FSM states and the statistics byte count.
package space_wire_stat_pkg;

  localparam int STAT_BYTES = 8;

  typedef enum logic [1:0] {
    CMD_INVALID = 2'b00,
    CMD_SNAP    = 2'b01,
    CMD_READ    = 2'b10,
    CMD_CLEAR   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_GUARD,
    ST_ACK
  } state_e;

endpackage

// File: rtl/space_wire_stat_arb.sv
// Two-way round-robin arbiter; the last-grant pointer only moves when the
// controller accepts a grant, so it reflects who was actually served.
module space_wire_stat_arb (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic accept_i,
  output logic grant_b_o,
  output logic last_b_o
);

  logic last_b_q;

  // B wins a tie only when A was the previous winner.
  assign grant_b_o = req_b_i & (~req_a_i | ~last_b_q);
  assign last_b_o  = last_b_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_b_q <= 1'b1;
    end else if (accept_i) begin
      last_b_q <= grant_b_o;
    end
  end

endmodule

// File: rtl/space_wire_stat_ctrl.sv
// Statistics access controller: serves SNAP / READ / CLEAR requests from two
// four-phase requesters, holding a private snapshot of the live stat bytes.
module space_wire_stat_ctrl
  import space_wire_stat_pkg::*;
#(
  parameter int CLEAR_GUARD = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic [1:0] i_cmd_a,
  input  logic [1:0] i_cmd_b,
  input  logic [2:0] i_addr_a,
  input  logic [2:0] i_addr_b,
  input  logic [7:0] i_stat_info_0,
  input  logic [7:0] i_stat_info_1,
  input  logic [7:0] i_stat_info_2,
  input  logic [7:0] i_stat_info_3,
  input  logic [7:0] i_stat_info_4,
  input  logic [7:0] i_stat_info_5,
  input  logic [7:0] i_stat_info_6,
  input  logic [7:0] i_stat_info_7,
  output logic       o_ack_a,
  output logic       o_ack_b,
  output logic [7:0] o_rdata,
  output logic       o_err,
  output logic       o_stat_clear,
  output logic       o_snap_valid
);

  localparam logic [3:0] GUARD_INIT = 4'(CLEAR_GUARD);

  state_e     state_q;
  cmd_e       cmd_q;
  cmd_e       cmd_d;
  logic [2:0] addr_q;
  logic [2:0] addr_d;
  logic       sel_b_q;
  logic [3:0] guard_q;
  logic [7:0] snap_q [STAT_BYTES];
  logic [7:0] stat_info [STAT_BYTES];
  logic       ack_a_q, ack_b_q, err_q, stat_clear_q, snap_valid_q;
  logic [7:0] rdata_q;
  logic       any_req, accept, grant_b, last_b, sel_req;

  assign stat_info[0] = i_stat_info_0;
  assign stat_info[1] = i_stat_info_1;
  assign stat_info[2] = i_stat_info_2;
  assign stat_info[3] = i_stat_info_3;
  assign stat_info[4] = i_stat_info_4;
  assign stat_info[5] = i_stat_info_5;
  assign stat_info[6] = i_stat_info_6;
  assign stat_info[7] = i_stat_info_7;

  assign any_req = i_req_a | i_req_b;
  assign accept  = (state_q == ST_IDLE) & any_req;
  assign cmd_d   = cmd_e'(grant_b ? i_cmd_b : i_cmd_a);
  assign addr_d  = grant_b ? i_addr_b : i_addr_a;
  assign sel_req = sel_b_q ? i_req_b : i_req_a;

  space_wire_stat_arb u_arb (
    .clk_i     (i_clk),
    .rst_ni    (i_reset_n),
    .req_a_i   (i_req_a),
    .req_b_i   (i_req_b),
    .accept_i  (accept),
    .grant_b_o (grant_b),
    .last_b_o  (last_b)
  );

  // Ack rises one cycle after entering ACK and falls once the served
  // requester releases its request; the clear pulse is registered so it
  // coincides exactly with the EXEC cycle of a CLEAR.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_INVALID;
      addr_q       <= '0;
      sel_b_q      <= 1'b0;
      guard_q      <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      stat_clear_q <= 1'b0;
      snap_valid_q <= 1'b0;
      for (int i = 0; i < STAT_BYTES; i++) snap_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q      <= ST_EXEC;
            sel_b_q      <= grant_b;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            stat_clear_q <= (cmd_d == CMD_CLEAR);
          end
        end
        ST_EXEC: begin
          stat_clear_q <= 1'b0;
          case (cmd_q)
            CMD_SNAP: begin
              for (int i = 0; i < STAT_BYTES; i++) snap_q[i] <= stat_info[i];
              snap_valid_q <= 1'b1;
              state_q      <= ST_ACK;
            end
            CMD_READ: begin
              rdata_q <= snap_valid_q ? snap_q[addr_q] : 8'h00;
              state_q <= ST_ACK;
            end
            CMD_CLEAR: begin
              for (int i = 0; i < STAT_BYTES; i++) snap_q[i] <= '0;
              snap_valid_q <= 1'b0;
              guard_q      <= GUARD_INIT;
              state_q      <= ST_GUARD;
            end
            default: begin
              err_q   <= 1'b1;
              state_q <= ST_ACK;
            end
          endcase
        end
        ST_GUARD: begin
          guard_q <= guard_q - 4'd1;
          if (guard_q <= 4'd1) state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (!ack_a_q && !ack_b_q) begin
            ack_a_q <= ~sel_b_q;
            ack_b_q <= sel_b_q;
          end else if (!sel_req) begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ack_a      = ack_a_q;
  assign o_ack_b      = ack_b_q;
  assign o_rdata      = rdata_q;
  assign o_err        = err_q;
  assign o_stat_clear = stat_clear_q;
  assign o_snap_valid = snap_valid_q;

  logic unused_last;
  assign unused_last = last_b;

endmodule

// File: tb/tb_space_wire_stat_ctrl.sv
// Directed bench for space_wire_stat_ctrl: arbitration, SNAP/READ/CLEAR,
// invalid command, latency and asynchronous reset mid-operation.
module tb_space_wire_stat_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [1:0] cmd_a = 2'b00, cmd_b = 2'b00;
  logic [2:0] addr_a = 3'd0, addr_b = 3'd0;
  logic [7:0] stat [8];
  logic       ack_a, ack_b, err, stat_clear, snap_valid;
  logic [7:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  space_wire_stat_ctrl #(.CLEAR_GUARD(2)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .i_cmd_a       (cmd_a),
    .i_cmd_b       (cmd_b),
    .i_addr_a      (addr_a),
    .i_addr_b      (addr_b),
    .i_stat_info_0 (stat[0]),
    .i_stat_info_1 (stat[1]),
    .i_stat_info_2 (stat[2]),
    .i_stat_info_3 (stat[3]),
    .i_stat_info_4 (stat[4]),
    .i_stat_info_5 (stat[5]),
    .i_stat_info_6 (stat[6]),
    .i_stat_info_7 (stat[7]),
    .o_ack_a       (ack_a),
    .o_ack_b       (ack_b),
    .o_rdata       (rdata),
    .o_err         (err),
    .o_stat_clear  (stat_clear),
    .o_snap_valid  (snap_valid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One complete four-phase transfer; edge 0 is the first rising edge after req.
  task automatic applyStimulus(input bit sideB, input logic [1:0] cmd,
                               input logic [2:0] addr, output int ackEdge,
                               output logic [7:0] rd, output logic er,
                               output int clrCount, output int clrEdge,
                               output bit otherAck);
    bit dropped;
    ackEdge = -1; rd = 8'hxx; er = 1'bx; clrCount = 0; clrEdge = -1; otherAck = 0;
    @(negedge clk);
    if (sideB) begin cmd_b = cmd; addr_b = addr; req_b = 1'b1; end
    else begin cmd_a = cmd; addr_a = addr; req_a = 1'b1; end
    for (int k = 1; k <= 30 && ackEdge < 0; k++) begin
      @(posedge clk); #1;
      if (stat_clear) begin
        clrCount++;
        if (clrEdge < 0) clrEdge = k - 1;
      end
      if (sideB ? ack_a : ack_b) otherAck = 1;
      if (sideB ? ack_b : ack_a) begin
        ackEdge = k - 1; rd = rdata; er = err;
      end
    end
    @(negedge clk);
    if (sideB) req_b = 1'b0; else req_a = 1'b0;
    dropped = 0;
    for (int k = 0; k < 5 && !dropped; k++) begin
      @(posedge clk); #1;
      if (!ack_a && !ack_b) dropped = 1;
    end
    checkOutput("ackDrop", 32'(dropped), 32'd1);
  endtask

  int ackEdge, clrCount, clrEdge, who;
  logic [7:0] rd;
  logic er;
  bit otherAck;

  initial begin
    for (int i = 0; i < 8; i++) stat[i] = 8'h10 + 8'(i);
    stat[3] = 8'h5A;

    #12;
    checkOutput("rst_ack_a", 32'(ack_a), 32'd0);
    checkOutput("rst_ack_b", 32'(ack_b), 32'd0);
    checkOutput("rst_clear", 32'(stat_clear), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_valid", 32'(snap_valid), 32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'h00);
    @(negedge clk); rst_n = 1'b1;

    $display("[TB] tie arbitration");
    @(negedge clk);
    cmd_a = 2'b10; cmd_b = 2'b10; req_a = 1'b1; req_b = 1'b1;
    for (int g = 0; g < 4; g++) begin
      who = -1;
      for (int k = 0; k < 30 && who < 0; k++) begin
        @(posedge clk); #1;
        if (ack_a) who = 0;
        else if (ack_b) who = 1;
      end
      checkOutput($sformatf("tieGrant%0d", g), 32'(who), 32'(g % 2));
      @(negedge clk);
      if (who == 1) req_b = 1'b0; else req_a = 1'b0;
      for (int k = 0; k < 5 && (ack_a || ack_b); k++) begin @(posedge clk); #1; end
      @(negedge clk);
      if (who == 1) req_b = 1'b1; else if (who == 0) req_a = 1'b1;
    end
    @(negedge clk); req_a = 1'b0; req_b = 1'b0;
    repeat (10) @(posedge clk);

    $display("[TB] READ before SNAP");
    applyStimulus(0, 2'b10, 3'd3, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("rdNoSnap_edge", 32'(ackEdge), 32'd2);
    checkOutput("rdNoSnap_data", 32'(rd), 32'h00);
    checkOutput("rdNoSnap_err", 32'(er), 32'd0);

    $display("[TB] SNAP then READ");
    applyStimulus(0, 2'b01, 3'd0, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("snap_edge", 32'(ackEdge), 32'd2);
    checkOutput("snap_err", 32'(er), 32'd0);
    checkOutput("snap_valid", 32'(snap_valid), 32'd1);
    applyStimulus(0, 2'b10, 3'd3, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("rd3_edge", 32'(ackEdge), 32'd2);
    checkOutput("rd3_data", 32'(rd), 32'h5A);
    checkOutput("rd3_err", 32'(er), 32'd0);

    $display("[TB] snapshot hold");
    stat[3] = 8'h77;
    applyStimulus(1, 2'b10, 3'd3, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("hold_data", 32'(rd), 32'h5A);
    applyStimulus(1, 2'b10, 3'd7, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("rd7_data", 32'(rd), 32'h17);

    $display("[TB] CLEAR");
    applyStimulus(1, 2'b11, 3'd0, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("clr_ackEdge", 32'(ackEdge), 32'd4);
    checkOutput("clr_pulses", 32'(clrCount), 32'd1);
    checkOutput("clr_pulseEdge", 32'(clrEdge), 32'd0);
    checkOutput("clr_valid", 32'(snap_valid), 32'd0);
    applyStimulus(0, 2'b10, 3'd3, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("rdAfterClr_data", 32'(rd), 32'h00);

    $display("[TB] invalid command");
    applyStimulus(1, 2'b00, 3'd5, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("inv_edge", 32'(ackEdge), 32'd2);
    checkOutput("inv_err", 32'(er), 32'd1);
    checkOutput("inv_data", 32'(rd), 32'h00);
    checkOutput("inv_ackA", 32'(otherAck), 32'd0);

    $display("[TB] reset during GUARD");
    @(negedge clk); cmd_a = 2'b11; req_a = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checkOutput("rstGuard_outs", 32'({ack_a, ack_b, stat_clear, err, snap_valid, rdata}), 32'd0);
    @(negedge clk); req_a = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(0, 2'b01, 3'd0, ackEdge, rd, er, clrCount, clrEdge, otherAck);
    checkOutput("postRst_snapEdge", 32'(ackEdge), 32'd2);
    checkOutput("postRst_valid", 32'(snap_valid), 32'd1);

    $display("[TB] reset during ACK");
    @(negedge clk); cmd_a = 2'b10; addr_a = 3'd3; req_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAck_pre_ack", 32'(ack_a), 32'd1);
    checkOutput("rstAck_pre_data", 32'(rdata), 32'h77);
    #2; rst_n = 1'b0; #1;
    checkOutput("rstAck_outs", 32'({ack_a, ack_b, stat_clear, err, snap_valid, rdata}), 32'd0);
    @(negedge clk); req_a = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/space_wire_stat_ctrl.md
SPACE_WIRE_STAT_CTRL -- requirements
Module: space_wire_stat_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_GUARD, default 2, meaning the number of i_clk cycles to wait after o_stat_clear before acknowledging a CLEAR (range 1..15).
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports i_req_a and i_req_b, input, 1 bit each: requester A and B request, four-phase.
REQ-005 SHALL have ports i_cmd_a and i_cmd_b, input, 2 bits each: command, where 01=SNAP, 10=READ, 11=CLEAR and 00=invalid.
REQ-006 SHALL have ports i_addr_a and i_addr_b, input, 3 bits each: stat byte index 0..7 for READ.
REQ-007 SHALL have ports i_stat_info_0 .. i_stat_info_7, input, 8 bits each: live statistics bytes.
REQ-008 SHALL have ports o_ack_a and o_ack_b, output, 1 bit each: acknowledge to the granted requester.
REQ-009 SHALL have port o_rdata, output, 8 bits: READ result, valid while either ack is high.
REQ-010 SHALL have port o_err, output, 1 bit: invalid command flag, valid while either ack is high.
REQ-011 SHALL have port o_stat_clear, output, 1 bit: one-cycle clear pulse to the statistics block.
REQ-012 SHALL have port o_snap_valid, output, 1 bit: the snapshot holds captured data.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, GUARD and ACK.
REQ-014 In IDLE with any request high, SHALL grant one requester, latch its cmd and addr, and go to EXEC on the next edge.
REQ-015 Arbitration SHALL be round-robin: when both request, grant the one not granted last; a lone requester is always granted.
REQ-016 EXEC for SNAP SHALL copy all eight i_stat_info bytes into the snapshot in the same edge, set o_snap_valid, and go to ACK.
REQ-017 EXEC for READ SHALL load o_rdata with snapshot[addr] and go to ACK; a READ with o_snap_valid low SHALL return 0x00 with o_err low.
REQ-018 EXEC for CLEAR SHALL drive o_stat_clear high for exactly that cycle, zero the snapshot, clear o_snap_valid, load the guard counter with CLEAR_GUARD, and go to GUARD.
REQ-019 GUARD SHALL decrement the counter each cycle and go to ACK when the counter reaches 1.
REQ-020 EXEC for an invalid command (00) SHALL set o_err and go to ACK with o_rdata at 0x00.
REQ-021 ACK SHALL hold only the granted requester's ack high, with o_rdata and o_err stable, until that requester's req is low.
REQ-022 ACK SHALL then return to IDLE and drop the ack on the next edge.
REQ-023 Latency: with req rising before edge 0, ack SHALL be high after edge 2 for SNAP, READ and invalid; for CLEAR, ack SHALL be high after edge 2+CLEAR_GUARD.
REQ-024 A request arriving while another is in service SHALL wait and SHALL NOT affect the transfer in service.
REQ-025 o_rdata and o_err SHALL be cleared on entry to EXEC for every command.

Reset
REQ-026 Asserting i_reset_n low at any time, including mid-operation, SHALL immediately force state IDLE.
REQ-027 Reset SHALL zero all outputs: o_ack_a, o_ack_b, o_stat_clear, o_err, o_snap_valid, and o_rdata = 0x00.
REQ-028 Reset SHALL zero the snapshot and guard counter, and set the last-granted pointer to B so that A wins the first tie.

Structure
REQ-029 A shared package SHALL hold the command encodings (SNAP, READ, CLEAR, invalid), the FSM state encodings, and the stat byte count of 8.
REQ-030 The round-robin arbiter SHALL be the one sub-module, space_wire_stat_arb, with inputs req_a, req_b and a grant-accept strobe, and a registered last-grant output.

Verification
REQ-031 SNAP then READ: stat_info_3=0x5A, A issues SNAP; A issues READ addr 3 -> ack at edge 2, o_rdata=0x5A, o_err=0.
REQ-032 Snapshot hold: after a SNAP capturing 0x5A, change stat_info_3 to 0x77; READ addr 3 -> o_rdata=0x5A (snapshot value, not live).
REQ-033 CLEAR with CLEAR_GUARD=2: o_stat_clear high for exactly 1 cycle at EXEC; ack at edge 4; o_snap_valid=0; a following READ returns 0x00.
REQ-034 Tie arbitration: A and B request in the same cycle after reset -> A served first, B served next; with both held continuously, grants alternate A,B,A,B.
REQ-035 Invalid command: B issues cmd 00 -> o_ack_b with o_err=1 and o_rdata=0x00; o_ack_a stays low throughout.
REQ-036 Reset mid-operation: assert reset during GUARD -> all outputs 0 immediately; after release, a new SNAP completes normally.
